hazard_controller: RTL

- Pipeline hazard/stall sequencer for the 5-stage RV32IM_Zbb core; sits beside the forwarding logic.
- Detects load-use and ID-stage branch-operand hazards and sequences the multi-cycle divider in EX with a start/done handshake.
- Drives PC/IF-ID enables, the ID/EX and IF/ID flushes, the divider start pulse, a stall counter and a watchdog flag.

---
 rtl/hazard_controller_if.sv | 47 ++++
 rtl/hazard_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard sources,
// divider handshake, stage enables/flushes and status.
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_address_id_i;
    logic [4:0]       rs2_address_id_i;
    logic             branch_id_i;
    logic             branch_taken_id_i;
    logic             rd_we_ex_i;
    logic             mem_to_reg_ex_i;
    logic [4:0]       rd_address_ex_i;
    logic             rd_we_mem_i;
    logic             mem_to_reg_mem_i;
    logic [4:0]       rd_address_mem_i;
    logic             div_ex_i;
    logic             div_done_i;
    logic             pc_en_o;
    logic             if_id_en_o;
    logic             if_id_flush_o;
    logic             id_ex_en_o;
    logic             id_ex_flush_o;
    logic             ex_mem_flush_o;
    logic             div_start_o;
    logic             div_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    // High while the divider handshake is outstanding (DIV_BUSY).
    logic             state_dbg_o;

    modport master (
        output rs1_address_id_i, rs2_address_id_i, branch_id_i, branch_taken_id_i,
               rd_we_ex_i, mem_to_reg_ex_i, rd_address_ex_i,
               rd_we_mem_i, mem_to_reg_mem_i, rd_address_mem_i,
               div_ex_i, div_done_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_flush_o, div_start_o, div_timeout_o, stall_cnt_o, state_dbg_o
    );

    modport slave (
        input  rs1_address_id_i, rs2_address_id_i, branch_id_i, branch_taken_id_i,
               rd_we_ex_i, mem_to_reg_ex_i, rd_address_ex_i,
               rd_we_mem_i, mem_to_reg_mem_i, rd_address_mem_i,
               div_ex_i, div_done_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_flush_o, div_start_o, div_timeout_o, stall_cnt_o, state_dbg_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / ID-branch hazard stalls and multi-cycle divider sequencing for the
// 5-stage core; also keeps a saturating stall counter and a sticky divider watchdog.
module hazard_controller #(
    parameter int unsigned DIV_TIMEOUT = 40,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave bus
);
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [7:0]       r_wdog;
    logic             r_div_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_lu;
    logic w_br;
    logic w_release;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;
    logic w_div_start;

    // x0 is never a real producer, so it can never create a dependency.
    assign w_ex_hit  = (bus.rd_address_ex_i != 5'd0) &&
                       ((bus.rd_address_ex_i == bus.rs1_address_id_i) ||
                        (bus.rd_address_ex_i == bus.rs2_address_id_i));
    assign w_mem_hit = (bus.rd_address_mem_i != 5'd0) &&
                       ((bus.rd_address_mem_i == bus.rs1_address_id_i) ||
                        (bus.rd_address_mem_i == bus.rs2_address_id_i));

    assign w_lu      = bus.mem_to_reg_ex_i & bus.rd_we_ex_i & w_ex_hit;
    assign w_br      = bus.branch_id_i &
                       ((bus.rd_we_ex_i & w_ex_hit) |
                        (bus.mem_to_reg_mem_i & bus.rd_we_mem_i & w_mem_hit));
    assign w_release = bus.div_done_i | (r_wdog == 8'(DIV_TIMEOUT - 1));

    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_div_start    = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.div_ex_i) begin
                    w_div_start    = 1'b1;
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                end else if (w_lu | w_br) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else if (bus.branch_taken_id_i) begin
                    w_if_id_flush = 1'b1;
                end
            end
            DIV_BUSY: begin
                // The release cycle opens every stage so EX/MEM captures the quotient.
                if (!w_release) begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_wdog        <= 8'd0;
            r_div_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.div_ex_i) begin
                        r_state <= DIV_BUSY;
                        r_wdog  <= 8'd0;
                    end
                end
                DIV_BUSY: begin
                    if (w_release) begin
                        r_state <= RUN;
                        if (!bus.div_done_i) begin
                            r_div_timeout <= 1'b1;
                        end
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
            if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.pc_en_o        = w_pc_en;
    assign bus.if_id_en_o     = w_if_id_en;
    assign bus.if_id_flush_o  = w_if_id_flush;
    assign bus.id_ex_en_o     = w_id_ex_en;
    assign bus.id_ex_flush_o  = w_id_ex_flush;
    assign bus.ex_mem_flush_o = w_ex_mem_flush;
    assign bus.div_start_o    = w_div_start;
    assign bus.div_timeout_o  = r_div_timeout;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.state_dbg_o    = (r_state == DIV_BUSY);
endmodule
